// File: rtl/dap_swo_pkg.sv
// Shared constants and types for the SWO UART capture block: register map, bit indices,
// receiver state encoding and the baud divider floor.
package dap_swo_pkg;

   localparam int unsigned OFF_CR     = 0;
   localparam int unsigned OFF_BAUD   = 1;
   localparam int unsigned OFF_STATUS = 2;
   localparam int unsigned OFF_DATA   = 3;

   localparam int unsigned CR_EN    = 0;
   localparam int unsigned CR_FLUSH = 1;

   localparam int unsigned ST_EMPTY     = 16;
   localparam int unsigned ST_FULL      = 17;
   localparam int unsigned ST_OVERRUN   = 18;
   localparam int unsigned ST_FRAME_ERR = 19;

   localparam logic [15:0] MIN_DIV = 16'd4;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   // Very small dividers cannot place a mid-bit sample, so clamp to the floor.
   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div < MIN_DIV) ? MIN_DIV : div;
   endfunction

endpackage

// File: rtl/dap_sync_fifo.sv
// Single-clock FIFO with occupancy count; flush overrides push/pop, and a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module dap_sync_fifo #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 6
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic [DW-1:0] o_data,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_empty
);

   localparam int unsigned DEPTH   = 1 << AW;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = r_count[AW];
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
         if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_ONE;
         else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push && !i_flush) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/dap_swo_uart_rx.sv
// SWO NRZ/UART (8N1, LSB first) receiver: synchroniser, mid-bit sampling FSM, byte FIFO and
// a four-word register window for firmware to drain captured trace bytes.
module dap_swo_uart_rx
   import dap_swo_pkg::*;
#(
   parameter int unsigned ADDRWIDTH = 12,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned FIFO_AW   = 6
) (
   input  logic                 i_clk,
   input  logic                 i_resetn,
   input  logic                 i_ahb_write_en,
   input  logic                 i_ahb_read_en,
   input  logic [ADDRWIDTH-1:0] i_ahb_addr,
   input  logic [31:0]          i_ahb_wdata,
   input  logic [3:0]           i_ahb_byte_strobe,
   output logic [31:0]          o_ahb_rdata,
   input  logic                 i_swo
);

   localparam logic [ADDRWIDTH-3:0] BASE_W = (ADDRWIDTH - 2)'(BASE_ADDR >> 2);

   logic              r_en, r_overrun, r_frame_err, r_sync1, r_sync2;
   logic [15:0]       r_div, r_div_lat, r_cnt;
   rx_state_e         r_state;
   logic [2:0]        r_idx;
   logic [7:0]        r_shift;
   logic              r_brk, r_push, r_fe_set;
   logic [ADDRWIDTH-3:0] w_word;
   logic              w_sel_cr, w_sel_baud, w_sel_st, w_sel_data;
   logic              w_rx, w_flush, w_pop, w_full, w_empty;
   logic              w_ovr_set, w_ovr_clr, w_fe_clr;
   logic [15:0]       w_div_eff;
   logic [7:0]        w_head;
   logic [FIFO_AW:0]  w_count;
   logic              w_unused;

   assign w_word     = i_ahb_addr[ADDRWIDTH-1:2];
   assign w_sel_cr   = (w_word == BASE_W + (ADDRWIDTH - 2)'(OFF_CR));
   assign w_sel_baud = (w_word == BASE_W + (ADDRWIDTH - 2)'(OFF_BAUD));
   assign w_sel_st   = (w_word == BASE_W + (ADDRWIDTH - 2)'(OFF_STATUS));
   assign w_sel_data = (w_word == BASE_W + (ADDRWIDTH - 2)'(OFF_DATA));
   assign w_rx       = r_sync2;
   assign w_div_eff  = eff_div(r_div);
   assign w_flush    = i_ahb_write_en & w_sel_cr & i_ahb_byte_strobe[0] & i_ahb_wdata[CR_FLUSH];
   assign w_pop      = i_ahb_read_en & w_sel_data & ~w_empty;
   // A byte lost to a full FIFO is only an overrun if no pop or flush made room for it.
   assign w_ovr_set  = r_push & w_full & ~w_pop & ~w_flush;
   assign w_ovr_clr  = i_ahb_write_en & w_sel_st & i_ahb_byte_strobe[2] & i_ahb_wdata[ST_OVERRUN];
   assign w_fe_clr   = i_ahb_write_en & w_sel_st & i_ahb_byte_strobe[2] & i_ahb_wdata[ST_FRAME_ERR];
   assign w_unused   = ^{i_ahb_addr[1:0], i_ahb_wdata[31:20], i_ahb_wdata[17:16],
                         i_ahb_byte_strobe[3]};

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_en        <= 1'b0;
         r_div       <= '0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
      end else begin
         r_sync1     <= i_swo;
         r_sync2     <= r_sync1;
         r_overrun   <= w_ovr_set | (r_overrun & ~w_ovr_clr);
         r_frame_err <= r_fe_set | (r_frame_err & ~w_fe_clr);
         if (i_ahb_write_en && w_sel_cr && i_ahb_byte_strobe[0]) r_en <= i_ahb_wdata[CR_EN];
         if (i_ahb_write_en && w_sel_baud) begin
            if (i_ahb_byte_strobe[0]) r_div[7:0]  <= i_ahb_wdata[7:0];
            if (i_ahb_byte_strobe[1]) r_div[15:8] <= i_ahb_wdata[15:8];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state   <= RX_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_shift   <= '0;
         r_div_lat <= MIN_DIV;
         r_brk     <= 1'b0;
         r_push    <= 1'b0;
         r_fe_set  <= 1'b0;
      end else begin
         r_push   <= 1'b0;
         r_fe_set <= 1'b0;
         if (!r_en) begin
            r_state <= RX_IDLE;
            r_brk   <= 1'b0;
         end else begin
            unique case (r_state)
               RX_IDLE: if (!w_rx) begin
                  r_state   <= RX_START;
                  r_div_lat <= w_div_eff;
                  r_cnt     <= (w_div_eff >> 1) - 16'd1;
               end
               RX_START: if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 16'd1;
               end else if (!w_rx) begin
                  r_state <= RX_DATA;
                  r_cnt   <= r_div_lat - 16'd1;
                  r_idx   <= '0;
               end else begin
                  r_state <= RX_IDLE;
               end
               RX_DATA: if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 16'd1;
               end else begin
                  r_shift[r_idx] <= w_rx;
                  r_cnt          <= r_div_lat - 16'd1;
                  r_idx          <= r_idx + 3'd1;
                  if (r_idx == 3'd7) r_state <= RX_STOP;
               end
               // After a low stop bit, hold here until the line returns high (break).
               RX_STOP: if (r_brk) begin
                  if (w_rx) begin
                     r_state <= RX_IDLE;
                     r_brk   <= 1'b0;
                  end
               end else if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 16'd1;
               end else if (w_rx) begin
                  r_push  <= 1'b1;
                  r_state <= RX_IDLE;
               end else begin
                  r_fe_set <= 1'b1;
                  r_brk    <= 1'b1;
               end
               default: r_state <= RX_IDLE;
            endcase
         end
      end
   end

   dap_sync_fifo #(
      .DW(8),
      .AW(FIFO_AW)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_resetn),
      .i_push  (r_push),
      .i_data  (r_shift),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .o_data  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      o_ahb_rdata = '0;
      if (w_sel_cr) begin
         o_ahb_rdata[CR_EN] = r_en;
      end else if (w_sel_baud) begin
         o_ahb_rdata[15:0] = r_div;
      end else if (w_sel_st) begin
         o_ahb_rdata[FIFO_AW:0]   = w_count;
         o_ahb_rdata[ST_EMPTY]     = w_empty;
         o_ahb_rdata[ST_FULL]      = w_full;
         o_ahb_rdata[ST_OVERRUN]   = r_overrun;
         o_ahb_rdata[ST_FRAME_ERR] = r_frame_err;
      end else if (w_sel_data && !w_empty) begin
         o_ahb_rdata[7:0] = w_head;
         o_ahb_rdata[8]   = 1'b1;
      end
   end

endmodule
